logic_pod_capture_sequencer: RTL and testbench
==============================================

// Module: logic_pod_capture_sequencer
// PURPOSE
//  Capture controller for one logic pod in the 312.5 MHz domain. Consumes the 8+8 bit per-cycle p/n samples from
//  the pod sampling FIFO, runs arm -> pretrigger fill -> trigger wait -> posttrigger count, and drives write
//  address/enable of a circular capture buffer. Reports trigger position and completion to the control plane.
// PARAMETERS
//  ADDR_BITS      12   capture buffer address width; depth = 2**ADDR_BITS samples
// PORTS
//  clk_312p5mhz   in   1          sole clock; all logic in this domain
//  rst            in   1          synchronous, active-high reset
//  arm            in   1          pulse: latch config, start capture
//  abort          in   1          pulse: cancel capture, return to IDLE
//  pretrig_depth  in   ADDR_BITS  samples stored before trigger is honoured (latched at arm)
//  posttrig_depth in   ADDR_BITS  samples stored after trigger sample (latched at arm)
//  trig_mask      in   8          bits of p used in trigger compare (latched at arm)
//  trig_match     in   8          required value of masked p bits (latched at arm)
//  p_in           in   8          p samples, one word per clock, always valid
//  n_in           in   8          n samples, same timing as p_in
//  buf_wr_en      out  1          capture buffer write strobe
//  buf_wr_addr    out  ADDR_BITS  capture buffer write address
//  buf_wr_data    out  16         {n, p} of the sample being written
//  busy           out  1          high in PRE, WAIT, POST
//  triggered      out  1          high from trigger sample until next arm/abort/rst
//  done           out  1          high in DONE
//  cfg_err        out  1          arm rejected: pretrig+posttrig+1 > 2**ADDR_BITS; cleared on next accepted arm
//  trig_addr      out  ADDR_BITS  buffer address holding the trigger sample
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. All outputs 0 on reset; state = IDLE.
//  - Input stage: {n_in,p_in} registered once; buf_wr_data = that register, so a sample on p_in at cycle t
//    is written with buf_wr_en at t+1. Trigger compare uses the same registered sample.
//  - match = ((p_reg & mask) == (match_cfg & mask)); trigger event = match && !match_prev (rising edge).
//    match_prev forced to 1 on arm, so a level already true at arm never triggers; a new edge is needed.
//  - States: IDLE -> PRE -> WAIT -> POST -> DONE.
//    IDLE: wr_en 0. arm: if pretrig+posttrig+1 > 2**ADDR_BITS set cfg_err, stay IDLE; else latch config,
//      addr <= 0, count <= 0, go PRE (or WAIT if pretrig_depth == 0).
//    PRE: wr_en 1 every cycle; after pretrig_depth writes go WAIT. Trigger events ignored.
//    WAIT: wr_en 1 every cycle, addr wraps modulo depth. On trigger event: that sample is written,
//      trig_addr <= its address, triggered <= 1; go POST (or DONE if posttrig_depth == 0).
//    POST: wr_en 1; after posttrig_depth further writes go DONE. Last write = trig_addr+posttrig (mod depth).
//    DONE: wr_en 0, done 1; hold until arm (restart) or abort/rst.
//  - Address increments by 1 per write, wraps 2**ADDR_BITS-1 -> 0, no stall (no backpressure on input).
//  - arm while busy: ignored. abort in any state: IDLE next cycle, wr_en 0 that cycle, done/triggered cleared.
//    arm and abort same cycle: abort wins. rst mid-capture: identical to abort plus cfg_err cleared.
//  - Counters ADDR_BITS+1 wide; depth comparisons are unsigned, no truncation.
// STRUCTURE
//  - logic_pod_pkg: capture_state_t enum (IDLE, PRE, WAIT, POST, DONE), LOGIC_POD_SAMPLE_BITS = 16.
//  - Sub-module logic_pod_trigger_match: registered mask/match compare + edge detect, 1-cycle latency,
//    clear input for the arm-time match_prev = 1 preload.
// TESTING
//  1 ADDR_BITS=4, pre=3, post=2, mask=0x01, match=0x01, p toggles bit0 at cycle 10 -> addrs 0..N written,
//    trig_addr = addr of that sample, exactly 2 more writes, done=1, wr_en 0 afterwards.
//  2 p bit0 held 1 from before arm, pre=0 -> no trigger until bit0 falls and rises again; addr wraps 15 -> 0.
//  3 Trigger edge during PRE (pre=5) -> ignored; triggered stays 0 until edge after 5th write.
//  4 pre=10, post=6, ADDR_BITS=4 (17 > 16) -> cfg_err=1, busy=0, no writes; then pre=9 -> accepted, cfg_err=0.
//  5 abort in POST, and arm+abort same cycle in IDLE -> IDLE next cycle, wr_en 0, done 0, triggered 0.
//  6 rst asserted mid-WAIT -> all outputs 0 next cycle; re-arm restarts at addr 0.

Source files
------------

// File: rtl/logic_pod_pkg.sv
// rtl/logic_pod_pkg.sv - shared types for the logic pod capture sequencer
package logic_pod_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT,
    POST,
    DONE
  } capture_state_t;

  localparam int LOGIC_POD_SAMPLE_BITS = 16;

endpackage

// File: rtl/logic_pod_trigger_match.sv
// rtl/logic_pod_trigger_match.sv - registered mask/match compare with rising-edge detect
module logic_pod_trigger_match (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [7:0] p,
  input  logic [7:0] mask,
  input  logic [7:0] match,
  output logic       trig_event
);

  logic hit;
  logic hit_prev;

  // hit is registered alongside the sample register, so trig_event lines up with the write of that sample
  always_ff @(posedge clk) begin
    if (rst) begin
      hit      <= 1'b0;
      hit_prev <= 1'b1;
    end else begin
      hit      <= ((p & mask) == (match & mask));
      hit_prev <= clear ? 1'b1 : hit;
    end
  end

  assign trig_event = hit && !hit_prev;

endmodule

// File: rtl/logic_pod_capture_sequencer.sv
// rtl/logic_pod_capture_sequencer.sv - arm/pretrigger/trigger/posttrigger capture control for one pod
module logic_pod_capture_sequencer
  import logic_pod_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                             clk_312p5mhz,
  input  logic                             rst,
  input  logic                             arm,
  input  logic                             abort,
  input  logic [ADDR_BITS-1:0]             pretrig_depth,
  input  logic [ADDR_BITS-1:0]             posttrig_depth,
  input  logic [7:0]                       trig_mask,
  input  logic [7:0]                       trig_match,
  input  logic [7:0]                       p_in,
  input  logic [7:0]                       n_in,
  output logic                             buf_wr_en,
  output logic [ADDR_BITS-1:0]             buf_wr_addr,
  output logic [LOGIC_POD_SAMPLE_BITS-1:0] buf_wr_data,
  output logic                             busy,
  output logic                             triggered,
  output logic                             done,
  output logic                             cfg_err,
  output logic [ADDR_BITS-1:0]             trig_addr
);

  localparam logic [ADDR_BITS+1:0] DEPTH = {2'b01, {ADDR_BITS{1'b0}}};

  capture_state_t state, next_state;

  logic [ADDR_BITS-1:0]             addr;
  logic [ADDR_BITS:0]               count;
  logic [ADDR_BITS:0]               count_inc;
  logic [ADDR_BITS-1:0]             pre_q;
  logic [ADDR_BITS-1:0]             post_q;
  logic [7:0]                       mask_q;
  logic [7:0]                       match_q;
  logic [LOGIC_POD_SAMPLE_BITS-1:0] sample;
  logic [ADDR_BITS+1:0]             span;
  logic                             cfg_bad;
  logic                             arm_idle;
  logic                             arm_accept;
  logic                             trig_event;

  assign span       = {2'b00, pretrig_depth} + {2'b00, posttrig_depth} + (ADDR_BITS+2)'(1);
  assign cfg_bad    = span > DEPTH;
  assign arm_idle   = arm && !abort && (state == IDLE || state == DONE);
  assign arm_accept = arm_idle && !cfg_bad;
  assign count_inc  = count + (ADDR_BITS+1)'(1);

  // The arm cycle's sample is compared against the incoming config, not the stale latched one
  logic_pod_trigger_match u_trigger_match (
    .clk        (clk_312p5mhz),
    .rst        (rst),
    .clear      (arm_accept),
    .p          (p_in),
    .mask       (arm_accept ? trig_mask : mask_q),
    .match      (arm_accept ? trig_match : match_q),
    .trig_event (trig_event)
  );

  always_ff @(posedge clk_312p5mhz) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (arm) next_state = cfg_bad ? IDLE : ((pretrig_depth == '0) ? WAIT : PRE);
        PRE:        if (count_inc == {1'b0, pre_q}) next_state = WAIT;
        WAIT:       if (trig_event) next_state = (post_q == '0) ? DONE : POST;
        POST:       if (count_inc == {1'b0, post_q}) next_state = DONE;
        default:    next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_312p5mhz) begin
    if (rst) begin
      sample    <= '0;
      addr      <= '0;
      count     <= '0;
      pre_q     <= '0;
      post_q    <= '0;
      mask_q    <= '0;
      match_q   <= '0;
      trig_addr <= '0;
      triggered <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      sample <= {n_in, p_in};
      if (abort) begin
        triggered <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (arm_idle) begin
              triggered <= 1'b0;
              cfg_err   <= cfg_bad;
              if (!cfg_bad) begin
                pre_q   <= pretrig_depth;
                post_q  <= posttrig_depth;
                mask_q  <= trig_mask;
                match_q <= trig_match;
                addr    <= '0;
                count   <= '0;
              end
            end
          end
          PRE: begin
            addr  <= addr + ADDR_BITS'(1);
            count <= (count_inc == {1'b0, pre_q}) ? '0 : count_inc;
          end
          WAIT: begin
            addr <= addr + ADDR_BITS'(1);
            if (trig_event) begin
              trig_addr <= addr;
              triggered <= 1'b1;
              count     <= '0;
            end
          end
          POST: begin
            addr  <= addr + ADDR_BITS'(1);
            count <= count_inc;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy        = (state == PRE) || (state == WAIT) || (state == POST);
  assign buf_wr_en   = busy;
  assign done        = (state == DONE);
  assign buf_wr_addr = addr;
  assign buf_wr_data = sample;

endmodule

// File: tb/tb_logic_pod_capture_sequencer.sv
// tb/tb_logic_pod_capture_sequencer.sv - directed self-checking bench for the capture sequencer
`timescale 1ns/1ps
module tb_logic_pod_capture_sequencer;

  localparam int AB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          arm;
  logic          abort;
  logic [AB-1:0] pretrig_depth;
  logic [AB-1:0] posttrig_depth;
  logic [7:0]    trig_mask;
  logic [7:0]    trig_match;
  logic [7:0]    p_in;
  logic [7:0]    n_in;
  logic          buf_wr_en;
  logic [AB-1:0] buf_wr_addr;
  logic [15:0]   buf_wr_data;
  logic          busy;
  logic          triggered;
  logic          done;
  logic          cfg_err;
  logic [AB-1:0] trig_addr;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [AB-1:0] pre;
    logic [AB-1:0] post;
    logic          err;
  } cfg_vec_t;

  cfg_vec_t vecs[8];

  always #1.6 clk = ~clk;

  logic_pod_capture_sequencer #(.ADDR_BITS(AB)) dut (
    .clk_312p5mhz   (clk),
    .rst            (rst),
    .arm            (arm),
    .abort          (abort),
    .pretrig_depth  (pretrig_depth),
    .posttrig_depth (posttrig_depth),
    .trig_mask      (trig_mask),
    .trig_match     (trig_match),
    .p_in           (p_in),
    .n_in           (n_in),
    .buf_wr_en      (buf_wr_en),
    .buf_wr_addr    (buf_wr_addr),
    .buf_wr_data    (buf_wr_data),
    .busy           (busy),
    .triggered      (triggered),
    .done           (done),
    .cfg_err        (cfg_err),
    .trig_addr      (trig_addr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  task automatic step(input logic [7:0] p);
    p_in = p;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int pre, input int post, input logic [7:0] m, input logic [7:0] v);
    pretrig_depth  = AB'(pre);
    posttrig_depth = AB'(post);
    trig_mask      = m;
    trig_match     = v;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_en"},   buf_wr_en,   0);
    check({tag, "_addr"},    buf_wr_addr, 0);
    check({tag, "_data"},    buf_wr_data, 0);
    check({tag, "_busy"},    busy,        0);
    check({tag, "_trig"},    triggered,   0);
    check({tag, "_done"},    done,        0);
    check({tag, "_cfg_err"}, cfg_err,     0);
    check({tag, "_trig_ad"}, trig_addr,   0);
  endtask

  initial begin
    vecs[0] = '{pre: 4'd10, post: 4'd6,  err: 1'b1};
    vecs[1] = '{pre: 4'd9,  post: 4'd6,  err: 1'b0};
    vecs[2] = '{pre: 4'd15, post: 4'd1,  err: 1'b1};
    vecs[3] = '{pre: 4'd15, post: 4'd0,  err: 1'b0};
    vecs[4] = '{pre: 4'd8,  post: 4'd8,  err: 1'b1};
    vecs[5] = '{pre: 4'd0,  post: 4'd15, err: 1'b0};
    vecs[6] = '{pre: 4'd15, post: 4'd15, err: 1'b1};
    vecs[7] = '{pre: 4'd7,  post: 4'd8,  err: 1'b0};

    rst = 1'b1; arm = 1'b0; abort = 1'b0; n_in = 8'hA5;
    set_cfg(0, 0, 8'h00, 8'h00);
    step(8'h00);
    step(8'h00);
    check_all_zero("reset");
    rst = 1'b0;

    // trigger on rising bit0 in WAIT, two posttrigger writes
    set_cfg(3, 2, 8'h01, 8'h01);
    arm = 1'b1; step(8'h00); arm = 1'b0;
    check("s1_pre_addr", buf_wr_addr, 0);
    check("s1_pre_en", buf_wr_en, 1);
    step(8'h00); step(8'h00); step(8'h00); step(8'h00);
    arm = 1'b1; step(8'h00); arm = 1'b0;
    check("s1_arm_busy_ignored", buf_wr_addr, 5);
    step(8'h00);
    step(8'h01);
    check("s1_trig_sample_addr", buf_wr_addr, 7);
    check("s1_trig_sample_data", buf_wr_data, 16'hA501);
    check("s1_not_yet_trig", triggered, 0);
    step(8'h01);
    check("s1_triggered", triggered, 1);
    check("s1_trig_addr", trig_addr, 7);
    check("s1_post0_addr", buf_wr_addr, 8);
    step(8'h01);
    check("s1_post1_addr", buf_wr_addr, 9);
    check("s1_post1_en", buf_wr_en, 1);
    check("s1_post1_done", done, 0);
    step(8'h01);
    check("s1_done", done, 1);
    check("s1_done_en", buf_wr_en, 0);
    check("s1_done_busy", busy, 0);
    step(8'h01);
    check("s1_done_hold", done, 1);

    // level true at arm must not trigger; address wraps
    set_cfg(0, 1, 8'h01, 8'h01);
    arm = 1'b1; step(8'h01); arm = 1'b0;
    check("s2_wait_addr0", buf_wr_addr, 0);
    check("s2_trig_cleared", triggered, 0);
    for (int i = 1; i <= 20; i++) begin
      step(8'h01);
      if (i == 16) check("s2_wrap", buf_wr_addr, 0);
    end
    check("s2_level_no_trig", triggered, 0);
    check("s2_addr_after", buf_wr_addr, 4);
    step(8'h00);
    step(8'h01);
    check("s2_edge_addr", buf_wr_addr, 6);
    step(8'h01);
    check("s2_triggered", triggered, 1);
    check("s2_trig_addr", trig_addr, 6);
    step(8'h01);
    check("s2_done", done, 1);

    // edge during pretrigger is ignored
    set_cfg(5, 1, 8'h01, 8'h01);
    arm = 1'b1; step(8'h00); arm = 1'b0;
    for (int i = 1; i <= 6; i++) step(8'h01);
    check("s3_pre_edge_ignored", triggered, 0);
    check("s3_busy", busy, 1);
    step(8'h00);
    step(8'h01);
    step(8'h01);
    check("s3_triggered", triggered, 1);
    check("s3_trig_addr", trig_addr, 8);
    step(8'h01);
    check("s3_done", done, 1);

    // depth validation table
    abort = 1'b1; step(8'h00); abort = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_cfg(int'(vecs[i].pre), int'(vecs[i].post), 8'h00, 8'h00);
      arm = 1'b1; step(8'h00); arm = 1'b0;
      check($sformatf("s4_cfg_err_%0d", i), cfg_err, vecs[i].err);
      check($sformatf("s4_busy_%0d", i), busy, !vecs[i].err);
      check($sformatf("s4_wr_en_%0d", i), buf_wr_en, !vecs[i].err);
      abort = 1'b1; step(8'h00); abort = 1'b0;
      check($sformatf("s4_idle_%0d", i), busy, 0);
    end

    // abort in POST, then arm+abort together in IDLE
    set_cfg(1, 4, 8'h01, 8'h01);
    arm = 1'b1; step(8'h00); arm = 1'b0;
    step(8'h00);
    step(8'h01);
    step(8'h01);
    check("s5_in_post_trig", triggered, 1);
    check("s5_in_post_addr", buf_wr_addr, 3);
    abort = 1'b1; step(8'h01); abort = 1'b0;
    check("s5_abort_en", buf_wr_en, 0);
    check("s5_abort_busy", busy, 0);
    check("s5_abort_trig", triggered, 0);
    check("s5_abort_done", done, 0);
    arm = 1'b1; abort = 1'b1; step(8'h00); arm = 1'b0; abort = 1'b0;
    check("s5_armabort_busy", busy, 0);
    check("s5_armabort_en", buf_wr_en, 0);
    check("s5_armabort_done", done, 0);
    check("s5_armabort_trig", triggered, 0);

    // reset clears cfg_err; reset mid-WAIT; re-arm restarts at 0
    set_cfg(10, 6, 8'h01, 8'h01);
    arm = 1'b1; step(8'h00); arm = 1'b0;
    check("s6_cfg_err_set", cfg_err, 1);
    rst = 1'b1; step(8'h00); rst = 1'b0;
    check("s6_rst_cfg_err", cfg_err, 0);
    set_cfg(0, 2, 8'h01, 8'h01);
    arm = 1'b1; step(8'h00); arm = 1'b0;
    step(8'h00); step(8'h00); step(8'h00);
    check("s6_wait_addr", buf_wr_addr, 3);
    rst = 1'b1; step(8'h00); rst = 1'b0;
    check_all_zero("s6_rst");
    arm = 1'b1; step(8'h00); arm = 1'b0;
    check("s6_rearm_addr", buf_wr_addr, 0);
    check("s6_rearm_busy", busy, 1);
    step(8'h00);
    check("s6_rearm_addr1", buf_wr_addr, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
